// File: rtl/inst_encode_loader.sv
// inst_encode_loader
//
// Packs decoded instruction fields and a signed 32-bit immediate into an
// RV32I word (I, S or B format, or a raw word) and writes it into
// instruction memory at a self-incrementing word address. Each word is held
// on the write port until the memory accepts it, then the address and the
// word count advance.
//
// Optional feature (macro ENCODER_RANGE_CHECK_EN): immediates that do not
// fit the selected format are rejected. The bundle is consumed, no write
// is issued, and the sticky ErrFlag is set. Without the macro, immediates
// are truncated to the format's bits and ErrFlag is tied low.
//
// Parameters
//   ADDR_W     instruction memory word-address width
//   BASE_ADDR  first word address written after reset or Start
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   Start      synchronous restart (address, count, Full, ErrFlag cleared)
//   InValid    field bundle valid
//   InReady    bundle can be accepted this cycle
//   Format     00 I, 01 S, 10 B, 11 raw word
//   Rd/Rs1/Rs2 register fields
//   Funct3     funct3 field
//   Imm        signed immediate, or the full word for raw format
//   MemWE      write request, held until MemReady
//   MemAddr    write word address
//   MemWData   encoded instruction
//   MemReady   memory accepts the write on this edge
//   WordCount  words written since reset/Start
//   Full       WordCount == 2^ADDR_W
//   ErrFlag    sticky immediate-rejected flag
module inst_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic               InValid,
  output logic               InReady,
  input  logic [1:0]         Format,
  input  logic [4:0]         Rd,
  input  logic [4:0]         Rs1,
  input  logic [4:0]         Rs2,
  input  logic [2:0]         Funct3,
  input  logic signed [31:0] Imm,
  output logic               MemWE,
  output logic [ADDR_W-1:0]  MemAddr,
  output logic [31:0]        MemWData,
  input  logic               MemReady,
  output logic [ADDR_W:0]    WordCount,
  output logic               Full,
  output logic               ErrFlag
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  function automatic logic [31:0] encode(
    input logic [1:0]         fmt,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic [2:0]         f3,
    input logic signed [31:0] imm
  );
    logic [31:0] w;
    case (fmt)
      2'b00:   w = {imm[11:0], rs1, f3, rd, OP_I};
      2'b01:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
      2'b10:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
      default: w = imm;
    endcase
    return w;
  endfunction

`ifdef ENCODER_RANGE_CHECK_EN
  // B offsets are halfword-aligned, so bit 0 must be clear to round-trip.
  function automatic logic imm_in_range(
    input logic [1:0]         fmt,
    input logic signed [31:0] imm
  );
    logic ok;
    case (fmt)
      2'b00, 2'b01: ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
      2'b10:        ok = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              accept;
  logic              reject;

  // Count never exceeds 2^ADDR_W because Full blocks accepts, so the MSB
  // alone marks Full.
  assign Full      = count_q[ADDR_W];
  assign InReady   = (state_q == IDLE) && !Full && !Start;
  assign accept    = InValid && InReady;
  assign MemWE     = (state_q == HOLD);
  assign MemAddr   = addr_q;
  assign MemWData  = wdata_q;
  assign WordCount = count_q;

`ifdef ENCODER_RANGE_CHECK_EN
  logic err_q, err_d;

  assign reject  = accept && !imm_in_range(Format, Imm);
  assign ErrFlag = err_q;

  always_comb begin
    err_d = err_q;
    if (Start)       err_d = 1'b0;
    else if (reject) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign reject  = 1'b0;
  assign ErrFlag = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    // Start wins over both a new accept and a completing write.
    if (Start) begin
      state_d = IDLE;
      addr_d  = BASE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && !reject) begin
            wdata_d = encode(Format, Rd, Rs1, Rs2, Funct3, Imm);
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (MemReady) begin
            state_d = IDLE;
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_inst_encode_loader.sv
module tb_inst_encode_loader;

  localparam int AW   = 2;
  localparam int BASE = 1;
  localparam int NW   = 1 << AW;

  logic               clk;
  logic               rst_n;
  logic               Start;
  logic               InValid;
  logic               InReady;
  logic [1:0]         Format;
  logic [4:0]         Rd, Rs1, Rs2;
  logic [2:0]         Funct3;
  logic signed [31:0] Imm;
  logic               MemWE;
  logic [AW-1:0]      MemAddr;
  logic [31:0]        MemWData;
  logic               MemReady;
  logic [AW:0]        WordCount;
  logic               Full;
  logic               ErrFlag;

  inst_encode_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .InValid(InValid),
    .InReady(InReady), .Format(Format), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
    .Funct3(Funct3), .Imm(Imm), .MemWE(MemWE), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemReady(MemReady), .WordCount(WordCount),
    .Full(Full), .ErrFlag(ErrFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [31:0] imm;
    int          addr;
    logic [31:0] word;
  } wr_t;

  wr_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  // Transaction-level reference state
  bit m_busy;
  int m_addr;
  int m_count;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference encoder: field placement by shift-and-mask arithmetic.
  function automatic logic [31:0] ref_enc(input logic [1:0] fmt, input int rd, input int rs1,
                                          input int rs2, input int f3, input logic [31:0] imm);
    logic [31:0] regs;
    regs = (32'(rs1) << 15) + (32'(f3) << 12);
    case (fmt)
      2'd0: return ((imm & 32'hFFF) << 20) + regs + (32'(rd) << 7) + 32'h13;
      2'd1: return (((imm >> 5) & 32'h7F) << 25) + (32'(rs2) << 20) + regs
                   + ((imm & 32'h1F) << 7) + 32'h23;
      2'd2: return (((imm >> 12) & 32'h1) << 31) + (((imm >> 5) & 32'h3F) << 25)
                   + (32'(rs2) << 20) + regs + (((imm >> 1) & 32'hF) << 8)
                   + (((imm >> 11) & 32'h1) << 7) + 32'h63;
      default: return imm;
    endcase
  endfunction

  function automatic bit in_range(input logic [1:0] fmt, input int v);
    case (fmt)
      2'd0, 2'd1: return (v >= -2048) && (v <= 2047);
      2'd2:       return (v >= -4096) && (v <= 4094) && ((v & 1) == 0);
      default:    return 1'b1;
    endcase
  endfunction

  // Immediate as the core's decoder would regenerate it from a word.
  function automatic int decode_imm(input logic [1:0] fmt, input logic [31:0] w);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    case (fmt)
      2'd0: begin i12 = w[31:20];                          return int'(i12); end
      2'd1: begin i12 = {w[31:25], w[11:7]};               return int'(i12); end
      2'd2: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; return int'(b13); end
      default: return int'(w);
    endcase
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_addr  = BASE;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  // One cycle: drive inputs after the edge, check against the model,
  // then advance the model to the state after the next edge.
  task automatic cycle(input bit st, input bit iv, input logic [1:0] fmt, input int rd,
                       input int rs1, input int rs2, input int f3, input logic [31:0] imm,
                       input bit mr);
    bit exp_ready;
    bit rej;
    wr_t it;
    @(posedge clk); #1;
    Start = st; InValid = iv; Format = fmt; Rd = 5'(rd); Rs1 = 5'(rs1); Rs2 = 5'(rs2);
    Funct3 = 3'(f3); Imm = imm; MemReady = mr;
    #1;
    exp_ready = !m_busy && (m_count < NW) && !st;
    chk("InReady", 32'(InReady), 32'(exp_ready));
    chk("MemWE", 32'(MemWE), 32'(m_busy));
    chk("MemAddr", 32'(MemAddr), 32'(m_addr));
    chk("WordCount", 32'(WordCount), 32'(m_count));
    chk("Full", 32'(Full), 32'(m_count == NW));
    chk("ErrFlag", 32'(ErrFlag), 32'(m_err));
    if (st) begin
      model_reset();
    end else if (m_busy) begin
      if (mr) begin
        m_busy  = 1'b0;
        m_addr  = (m_addr + 1) % NW;
        m_count = m_count + 1;
      end
    end else if (iv && exp_ready) begin
`ifdef ENCODER_RANGE_CHECK_EN
      rej = !in_range(fmt, int'(imm));
`else
      rej = 1'b0;
`endif
      if (rej) m_err = 1'b1;
      else begin
        m_busy  = 1'b1;
        it.fmt  = fmt;
        it.imm  = imm;
        it.addr = m_addr;
        it.word = ref_enc(fmt, rd, rs1, rs2, f3, imm);
        exp_q.push_back(it);
      end
    end
  endtask

  task automatic idle(input bit mr);
    cycle(1'b0, 1'b0, 2'd0, 0, 0, 0, 0, 32'd0, mr);
  endtask

  task automatic wr(input logic [1:0] fmt, input int rd, input int rs1, input int rs2,
                    input int f3, input logic [31:0] imm, input int nhold);
    cycle(1'b0, 1'b1, fmt, rd, rs1, rs2, f3, imm, 1'b0);
    repeat (nhold) idle(1'b0);
    idle(1'b1);
    idle(1'b0);
  endtask

  // Monitor: pops an expected write when MemWE rises, then checks the
  // request stays stable while it is held.
  bit          prev_we = 1'b0;
  logic [31:0] cap_data;
  logic [AW-1:0] cap_addr;

  always @(negedge clk) begin
    wr_t it;
    if (!rst_n) begin
      prev_we = 1'b0;
    end else begin
      if (MemWE && !prev_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(MemWE), 32'd0);
        end else begin
          it = exp_q.pop_front();
          chk("wr_addr", 32'(MemAddr), 32'(it.addr));
          chk("wr_data", MemWData, it.word);
          if (it.fmt != 2'd3 && in_range(it.fmt, int'(it.imm)))
            chk("imm_roundtrip", 32'(decode_imm(it.fmt, MemWData)), it.imm);
        end
        cap_data = MemWData;
        cap_addr = MemAddr;
      end else if (MemWE && prev_we) begin
        chk("hold_data", MemWData, cap_data);
        chk("hold_addr", 32'(MemAddr), 32'(cap_addr));
        chk("hold_ready", 32'(InReady), 32'd0);
      end
      prev_we = MemWE;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges [9];
    edges = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4094, -32'sd4096,
              32'd4095, 32'd4096, -32'sd4097};
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return 32'($urandom_range(0, 4095)) - 32'd2048;
      2: return (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
      3: return edges[$urandom_range(0, 8)];
      default: return 32'($urandom_range(0, 63)) - 32'd32;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; Start = 1'b0; InValid = 1'b0; Format = 2'd0; Rd = '0; Rs1 = '0;
    Rs2 = '0; Funct3 = '0; Imm = '0; MemReady = 1'b0;
    model_reset();
    #12;
    chk("rst_MemWE", 32'(MemWE), 32'd0);
    chk("rst_MemAddr", 32'(MemAddr), 32'(BASE));
    chk("rst_MemWData", MemWData, 32'd0);
    chk("rst_WordCount", 32'(WordCount), 32'd0);
    chk("rst_Full", 32'(Full), 32'd0);
    chk("rst_ErrFlag", 32'(ErrFlag), 32'd0);
    chk("rst_InReady", 32'(InReady), 32'd1);
    #1 rst_n = 1'b1;

    // Directed words from the known encodings
    wr(2'd0, 5, 1, 0, 0, -32'sd1, 0);
    chk("I_word", MemWData, 32'hFFF08293);
    chk("I_count", 32'(WordCount), 32'd1);
    wr(2'd1, 0, 3, 2, 2, 32'd8, 0);
    chk("S_word", MemWData, 32'h0021A423);
    wr(2'd2, 0, 1, 2, 0, -32'sd4, 3);
    chk("B_word", MemWData, 32'hFE208EE3);
    chk("B_immext", 32'(decode_imm(2'd2, MemWData)), 32'hFFFFFFFC);
    wr(2'd0, 5, 1, 0, 0, 32'd2048, 0);
`ifdef ENCODER_RANGE_CHECK_EN
    chk("I2048_err", 32'(ErrFlag), 32'd1);
    chk("I2048_count", 32'(WordCount), 32'd3);
`else
    chk("I2048_word", MemWData, 32'h80008293);
    chk("I2048_count", 32'(WordCount), 32'd4);
`endif
    for (int k = 0; k < NW && m_count < NW; k++) wr(2'd3, 0, 0, 0, 0, $urandom, 1);

    // Full blocks further accepts
    cycle(1'b0, 1'b1, 2'd3, 0, 0, 0, 0, 32'h12345678, 1'b1);
    chk("full_flag", 32'(Full), 32'd1);
    chk("full_count", 32'(WordCount), 32'(NW));
    chk("full_ready", 32'(InReady), 32'd0);
    idle(1'b1);

    // Start aborts a pending write
    cycle(1'b1, 1'b1, 2'd0, 1, 1, 1, 1, 32'd1, 1'b0);
    cycle(1'b0, 1'b1, 2'd1, 1, 2, 3, 4, 32'd100, 1'b0);
    idle(1'b0);
    cycle(1'b1, 1'b0, 2'd0, 0, 0, 0, 0, 32'd0, 1'b1);
    idle(1'b0);
    chk("abort_MemWE", 32'(MemWE), 32'd0);
    chk("abort_MemAddr", 32'(MemAddr), 32'(BASE));
    chk("abort_count", 32'(WordCount), 32'd0);
    chk("abort_Full", 32'(Full), 32'd0);

    // Asynchronous reset drops a held write at once
    cycle(1'b0, 1'b1, 2'd0, 7, 8, 9, 3, 32'd77, 1'b0);
    idle(1'b0);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("arst_MemWE", 32'(MemWE), 32'd0);
    chk("arst_MemWData", MemWData, 32'd0);
    chk("arst_MemAddr", 32'(MemAddr), 32'(BASE));
    chk("arst_InReady", 32'(InReady), 32'd1);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 39) == 0, 1'($urandom), 2'($urandom), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7), rand_imm(),
            1'($urandom));
    end
    for (int n = 0; n < 4 && m_busy; n++) idle(1'b1);
    idle(1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_encode_loader.md
# inst_encode_loader

Instruction encoder and loader: accepts decoded instruction fields plus a signed 32-bit immediate, packs them into a 32-bit RV32I word in I/S/B format, and writes the word into instruction memory at a self-incrementing address. It is the inverse of the immediate-extension path in the core: a word it produces, once fetched and decoded, regenerates the original immediate. It sits between the test/boot front end and the instruction memory write port.

## Interface
- ADDR_W, 8: instruction memory word-address width.
- BASE_ADDR, 0: first word address written after reset or Start.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  synchronous restart: address, count, Full and ErrFlag cleared.
- InValid  in  1  field bundle valid.
- InReady  out  1  block can accept a bundle this cycle.
- Format  in  2  00 = I (op 0010011), 01 = S (0100011), 10 = B (1100011), 11 = raw (Imm is the full word).
- Rd, Rs1, Rs2  in  5 each  register fields.
- Funct3  in  3  funct3 field.
- Imm  in  32  signed immediate, or raw word for Format 11.
- MemWE  out  1  write request, held until accepted.
- MemAddr  out  ADDR_W  write word address.
- MemWData  out  32  encoded instruction.
- MemReady  in  1  memory accepts the write on this edge.
- WordCount  out  ADDR_W+1  words written since reset/Start.
- Full  out  1  WordCount == 2^ADDR_W.
- ErrFlag  out  1  sticky: an immediate was rejected.

## Operation
- FSM: IDLE, HOLD. Reset → IDLE.
- IDLE: InReady = !Full && !Start. On InValid && InReady: encode, register MemWData/MemAddr, MemWE = 1, go to HOLD.
- HOLD: InReady = 0. MemWE, MemAddr and MemWData are held stable. On an edge with MemReady = 1: MemWE = 0, address increments, WordCount increments, go to IDLE.
- Encoding:
  - I = {Imm[11:0], Rs1, Funct3, Rd, op}.
  - S = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], op}.
  - B = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], op}.
  - Raw = Imm.
- Address: wraps modulo 2^ADDR_W. Full blocks further accepts, so no write overwrites an earlier word in the same load.
- Start: has priority over InValid, so no accept occurs in that cycle. In HOLD, Start aborts the pending write: MemWE = 0 next cycle, no count increment. Address returns to BASE_ADDR; WordCount, Full and ErrFlag clear.
- Reset values: MemWE = 0, MemAddr = BASE_ADDR, MemWData = 0, WordCount = 0, Full = 0, ErrFlag = 0, InReady = 1.
- rst_n asserted mid-HOLD: the write is dropped immediately (asynchronous) and all outputs take their reset values.

## Timing
- Accept at edge N → MemWE/MemAddr/MemWData valid after N.
- Write completes at the first edge ≥ N+1 with MemReady = 1. IDLE resumes the following cycle.
- Peak throughput: one word per 2 cycles.
- InReady is combinational from state, Full and Start only. It has no path from InValid or MemReady.
- Full and WordCount update on the completing edge.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: on accept, I/S immediates must lie in [-2048, 2047]. B immediates must lie in [-4096, 4094] with Imm[0] = 0. Raw words are not checked.
  - A violation sets ErrFlag.
  - No write is issued and the FSM stays in IDLE; the bundle is consumed.
- ENCODER_RANGE_CHECK_EN undefined: no checking. Bits are taken as in the encoding rules (truncation), and ErrFlag is tied 0.

## Test plan
- I, Rd = 5, Rs1 = 1, Funct3 = 0, Imm = -1 → MemWData = 0xFFF08293, MemAddr = BASE_ADDR, WordCount = 1.
- S, Rs2 = 2, Rs1 = 3, Funct3 = 2, Imm = 8 → MemWData = 0x0021A423, at the next address.
- B, Rs2 = 2, Rs1 = 1, Funct3 = 0, Imm = -4 → MemWData = 0xFE208EE3. Feeding this word to the core decoder yields ImmExt = 0xFFFFFFFC.
- MemReady held low 3 cycles after accept → MemWE/MemAddr/MemWData stable and InReady = 0 throughout. Address advances only on the MemReady edge.
- I, Imm = 2048:
  - With the macro: no MemWE pulse, ErrFlag = 1, WordCount unchanged.
  - Without the macro: MemWData = 0x80008293.
- ADDR_W = 2: four writes → Full = 1, WordCount = 4, InReady = 0. Start asserted in HOLD with a pending write → MemWE drops, MemAddr = BASE_ADDR, WordCount = 0, Full = 0.
